// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared state type and constants for the instruction-memory fetch arbiter
package imem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } arb_state_e;

  localparam int FETCH_BYTES      = 4;
  localparam int IDX_W            = $clog2(FETCH_BYTES);
  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - byte lanes and little-endian instruction word register
module imem_word_assembler
  import imem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en_i,
  input  logic             done_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       rdata_i,
  output logic [31:0]      inst_o
);

  logic [7:0]  lane_q [FETCH_BYTES];
  logic [31:0] inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BYTES; i++) lane_q[i] <= '0;
      inst_q <= '0;
    end else begin
      if (cap_en_i) lane_q[idx_i] <= rdata_i;
      // The top byte arrives in the completing cycle, so take it straight from the read port.
      if (done_i) inst_q <= {rdata_i, lane_q[2], lane_q[1], lane_q[0]};
    end
  end

  assign inst_o = inst_q;

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - arbitrates loader byte writes and 4-byte instruction fetches on one memory port
// Optional fetch anti-starvation counter: IMEM_ARB_FAIRNESS_EN.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  input  logic              f_flush,
  output logic              f_ready,
  output logic              f_valid,
  output logic [31:0]       f_inst,
  output logic              f_misalign,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [7:0]        l_wdata,
  output logic              l_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_BYTES - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mis_q, mis_d;
  logic              f_valid_q, f_valid_d;
  logic              f_mis_q, f_mis_d;
  logic              accept, cap_en, done, fetch_prio;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  if (ADDR_W < 32) begin : g_unused_hi
    logic unused_f_addr_hi;
    assign unused_f_addr_hi = ^f_addr[31:ADDR_W];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    mis_d     = mis_q;
    f_valid_d = 1'b0;
    f_mis_d   = 1'b0;
    f_ready   = 1'b0;
    l_gnt     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cap_en    = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush in the accept cycle cancels the fetch by withholding f_ready.
        if (fetch_prio) begin
          f_ready = !f_flush;
        end else begin
          l_gnt   = l_req;
          f_ready = !l_req && !f_flush;
        end
        accept = f_req && f_ready;
        if (l_gnt) begin
          mem_we    = 1'b1;
          mem_addr  = l_addr;
          mem_wdata = l_wdata;
        end
        if (accept) begin
          base_d  = {f_addr[ADDR_W-1:2], 2'b00};
          mis_d   = |f_addr[1:0];
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_addr = base_q + {{(ADDR_W-IDX_W){1'b0}}, idx_q};
        if (f_flush) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          cap_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            done      = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
            f_valid_d = 1'b1;
            f_mis_d   = mis_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      mis_q     <= 1'b0;
      f_valid_q <= 1'b0;
      f_mis_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      mis_q     <= mis_d;
      f_valid_q <= f_valid_d;
      f_mis_q   <= f_mis_d;
    end
  end

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts back-to-back loader wins while a fetch is pending; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!f_req || accept) begin
      starve_d = '0;
    end else if (l_gnt && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign fetch_prio = (starve_q == CNT_W'(STARVE_LIMIT));
`else
  assign fetch_prio = 1'b0;
`endif

  imem_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .cap_en_i (cap_en),
    .done_i   (done),
    .idx_i    (idx_q),
    .rdata_i  (mem_rdata),
    .inst_o   (f_inst)
  );

  assign f_valid    = f_valid_q;
  assign f_misalign = f_mis_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - scoreboard bench for imem_fetch_arbiter with a behavioural byte memory
module tb_imem_fetch_arbiter;

  localparam int ADDR_W = 16;

  logic              clk, rst;
  logic              f_req, f_flush, f_ready, f_valid, f_misalign;
  logic [31:0]       f_addr, f_inst;
  logic              l_req, l_gnt, mem_we;
  logic [ADDR_W-1:0] l_addr, mem_addr;
  logic [7:0]        l_wdata, mem_wdata, mem_rdata;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [31:0] inst;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   valid_cnt = 0;

  imem_fetch_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_flush    (f_flush),
    .f_ready    (f_ready),
    .f_valid    (f_valid),
    .f_inst     (f_inst),
    .f_misalign (f_misalign),
    .l_req      (l_req),
    .l_addr     (l_addr),
    .l_wdata    (l_wdata),
    .l_gnt      (l_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && f_valid) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_f_valid: got inst %h at cycle %0d, required no f_valid", f_inst, cyc);
      end else begin
        e = sb.pop_front();
        chk("f_inst", f_inst, e.inst);
        chk("f_misalign", {31'd0, f_misalign}, {31'd0, e.mis});
        chk("f_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready(input string name, output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (f_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: f_ready got 0 for 40 cycles, required 1", name);
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp_inst,
                       input logic exp_mis, input bit resp, output int t);
    @(posedge clk); #1;
    f_req  = 1'b1;
    f_addr = addr;
    wait_ready(name, t);
    if (resp && t >= 0) sb.push_back('{exp_inst, exp_mis, t + 5});
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    l_req   = 1'b1;
    l_addr  = a;
    l_wdata = d;
    @(negedge clk);
    chk("load_l_gnt", {31'd0, l_gnt}, 32'd1);
    chk("load_mem_we", {31'd0, mem_we}, 32'd1);
    chk("load_mem_addr", {16'd0, mem_addr}, {16'd0, a});
    chk("load_mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
    @(posedge clk); #1;
    l_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk(name, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t, t2, first, gnts, vc;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    rst = 1'b1; f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
    l_req = 1'b0; l_addr = '0; l_wdata = '0;

    @(negedge clk);
    chk("rst_f_valid", {31'd0, f_valid}, 32'd0);
    chk("rst_f_inst", f_inst, 32'h0);
    chk("rst_f_misalign", {31'd0, f_misalign}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_f_ready", {31'd0, f_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    load(16'h0000, 8'h13); load(16'h0001, 8'h05); load(16'h0002, 8'hA0); load(16'h0003, 8'h00);
    load(16'h0004, 8'h93); load(16'h0005, 8'h05); load(16'h0006, 8'h10); load(16'h0007, 8'h00);
    load(16'hFFFC, 8'hEF); load(16'hFFFD, 8'hBE); load(16'hFFFE, 8'hAD); load(16'hFFFF, 8'hDE);

    @(negedge clk);
    chk("idle_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);

    fetch("fetch_0", 32'h0, 32'h00A00513, 1'b0, 1'b1, t);
    drain("drain_fetch_0");
    fetch("fetch_6", 32'h6, 32'h00100593, 1'b1, 1'b1, t);
    drain("drain_fetch_6");

    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h0;
    wait_ready("b2b_first", t);
    if (t >= 0) sb.push_back('{32'h00A00513, 1'b0, t + 5});
    @(posedge clk); #1;
    f_addr = 32'h4;
    wait_ready("b2b_second", t2);
    chk("b2b_gap", t2 - t, 32'd5);
    if (t2 >= 0) sb.push_back('{32'h00100593, 1'b0, t2 + 5});
    @(posedge clk); #1;
    f_req = 1'b0;
    drain("drain_b2b");

    vc = valid_cnt;
    fetch("flush_fetch", 32'h0, 32'h0, 1'b0, 1'b0, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    f_flush = 1'b1;
    @(posedge clk); #1;
    f_flush = 1'b0;
    @(negedge clk);
    chk("flush_f_ready", {31'd0, f_ready}, 32'd1);
    chk("flush_f_inst_held", f_inst, 32'h00100593);
    repeat (6) @(negedge clk);
    chk("flush_no_valid", valid_cnt, vc);

    vc = valid_cnt;
    @(posedge clk); #1;
    f_req = 1'b1; f_flush = 1'b1; f_addr = 32'h0;
    @(posedge clk); #1;
    f_req = 1'b0; f_flush = 1'b0;
    repeat (8) @(negedge clk);
    chk("flush_accept_cancel", valid_cnt, vc);

    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_addr = 16'h0100;
    first = -1; gnts = 0;
    for (int i = 0; i < 20; i++) begin
      l_wdata = 8'(i);
      @(negedge clk);
      if (i == 0) begin
        chk("prio_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("prio_f_ready", {31'd0, f_ready}, 32'd0);
      end
      if (l_gnt) gnts++;
      if (f_ready) begin
        if (first < 0) first = i;
        sb.push_back('{32'h00A00513, 1'b0, cyc + 5});
      end
      @(posedge clk); #1;
    end
`ifdef IMEM_ARB_FAIRNESS_EN
    chk("starve_first_accept", first, 32'd8);
    chk("starve_loader_grants", gnts, 32'd15);
`else
    chk("starve_first_accept", first, 32'hFFFFFFFF);
    chk("starve_loader_grants", gnts, 32'd20);
`endif
    l_req = 1'b0;
    wait_ready("starve_release", t);
    if (t >= 0) sb.push_back('{32'h00A00513, 1'b0, t + 5});
    @(posedge clk); #1;
    f_req = 1'b0;
    drain("drain_starve");

    vc = valid_cnt;
    fetch("rst_fetch", 32'h4, 32'h0, 1'b0, 1'b0, t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_f_valid", {31'd0, f_valid}, 32'd0);
    chk("midrst_f_inst", f_inst, 32'h0);
    chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_valid", valid_cnt, vc);

    fetch("fetch_wrap", 32'hFFFC, 32'hDEADBEEF, 1'b0, 1'b1, t);
    drain("drain_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
